// File: rtl/axi_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axi_mem_slave
//  Purpose  : AXI4 memory slave backed by a byte-addressed little-endian RAM.
//             Independent read and write FSMs, each handling one outstanding
//             INCR burst. Read data appears a fixed RD_LAT cycles after the
//             AR handshake and is registered, so it stays stable under
//             backpressure.
//  Revision : 1.0 - initial release
//
//  Ports
//    clk, rst                     : clock, asynchronous active-high reset
//    i_ar* / o_arready            : read address channel
//    o_r*  / i_rready             : read data channel
//    i_aw* / o_awready            : write address channel
//    i_w*  / o_wready             : write data channel
//    o_b*  / i_bready             : write response channel
//
//  Configuration macro
//    AXI_MEM_ERR_EN : when defined, beat addresses >= DEPTH_BYTES return
//                     SLVERR with zero data (reads) or are dropped (writes);
//                     a wlast mismatch or dropped beat yields bresp SLVERR.
//                     When undefined, addresses wrap modulo DEPTH_BYTES and
//                     all responses are OKAY.
// ============================================================================
module axi_mem_slave #(
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH_BYTES = 8192,
  parameter int RD_LAT      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  // read address channel
  input  logic [ID_WIDTH-1:0]   i_arid,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  input  logic [7:0]            i_arlen,
  input  logic [2:0]            i_arsize,
  input  logic [1:0]            i_arburst,
  input  logic                  i_arvalid,
  output logic                  o_arready,
  // read data channel
  output logic [ID_WIDTH-1:0]   o_rid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [1:0]            o_rresp,
  output logic                  o_rlast,
  output logic                  o_rvalid,
  input  logic                  i_rready,
  // write address channel
  input  logic [ID_WIDTH-1:0]   i_awid,
  input  logic [ADDR_WIDTH-1:0] i_awaddr,
  input  logic [7:0]            i_awlen,
  input  logic [2:0]            i_awsize,
  input  logic [1:0]            i_awburst,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  // write data channel
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_wlast,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  // write response channel
  output logic [ID_WIDTH-1:0]   o_bid,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready
);

  localparam int c_BYTES = DATA_WIDTH / 8;
  localparam int c_IDX_W = $clog2(DEPTH_BYTES);
  localparam int c_LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_LAT  = 2'd1,
    R_DATA = 2'd2
  } rstate_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  logic [7:0] mem_r [0:DEPTH_BYTES-1];

  // Held low through reset and released on the first edge afterwards, so the
  // address-ready outputs stay low while rst is asserted.
  logic r_live;

  // ---------------- read path signals ----------------
  rstate_t                 r_rstate, w_rstate_nxt;
  logic [ADDR_WIDTH-1:0]   r_raddr;
  logic [7:0]              r_rlen;
  logic [7:0]              r_rbeat;
  logic [c_LAT_W-1:0]      r_lat;
  logic [ID_WIDTH-1:0]     r_rid;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]              r_rresp;
  logic                    r_rlast;
  logic                    w_ar_hs;
  logic                    w_r_hs;
  logic                    w_lat_done;
  logic                    w_r_load;
  logic [ADDR_WIDTH-1:0]   w_rd_addr;
  logic [7:0]              w_rd_beat;
  logic [DATA_WIDTH-1:0]   w_rd_word;
  logic                    w_rd_err;

  // ---------------- write path signals ----------------
  wstate_t                 r_wstate, w_wstate_nxt;
  logic [ADDR_WIDTH-1:0]   r_waddr;
  logic [7:0]              r_wlen;
  logic [7:0]              r_wbeat;
  logic                    r_werr;
  logic [ID_WIDTH-1:0]     r_bid;
  logic [1:0]              r_bresp;
  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic                    w_w_final;
  logic                    w_wr_drop;
  logic                    w_wlast_err;
  logic                    w_werr_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_live <= 1'b0;
    else     r_live <= 1'b1;
  end

  // ==========================================================================
  // Read FSM
  // ==========================================================================
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rstate <= R_IDLE;
    else     r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    o_arready    = 1'b0;
    o_rvalid     = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        o_arready = r_live;
        if (r_live && i_arvalid) w_rstate_nxt = R_LAT;
      end
      R_LAT: begin
        if (w_lat_done) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        o_rvalid = 1'b1;
        if (i_rready && r_rlast) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  assign w_ar_hs    = o_arready & i_arvalid;
  assign w_r_hs     = o_rvalid & i_rready;
  assign w_lat_done = (r_rstate == R_LAT) && (r_lat == c_LAT_W'(RD_LAT - 1));

  // rdata is loaded when leaving R_LAT (beat 0) and on every non-final
  // handshake (next beat). Loading from the array with non-blocking writes
  // means a same-edge write is not yet visible: reads see pre-write data.
  assign w_r_load  = w_lat_done | (w_r_hs & ~r_rlast);
  assign w_rd_addr = (r_rstate == R_DATA) ? r_raddr + ADDR_WIDTH'(c_BYTES) : r_raddr;
  assign w_rd_beat = (r_rstate == R_DATA) ? r_rbeat + 8'd1 : r_rbeat;

  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < c_BYTES; i++) begin
      w_rd_word[8*i +: 8] = mem_r[c_IDX_W'(w_rd_addr[c_IDX_W-1:0] + c_IDX_W'(i))];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_raddr <= '0;
      r_rlen  <= '0;
      r_rbeat <= '0;
      r_lat   <= '0;
      r_rid   <= '0;
      r_rdata <= '0;
      r_rresp <= 2'b00;
      r_rlast <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_raddr <= i_araddr;
        r_rlen  <= i_arlen;
        r_rid   <= i_arid;
        r_rbeat <= '0;
        r_lat   <= '0;
      end else if ((r_rstate == R_LAT) && !w_lat_done) begin
        r_lat <= r_lat + c_LAT_W'(1);
      end
      if (w_r_load) begin
        r_raddr <= w_rd_addr;
        r_rbeat <= w_rd_beat;
        r_rdata <= w_rd_err ? '0 : w_rd_word;
        r_rresp <= w_rd_err ? 2'b10 : 2'b00;
        r_rlast <= (w_rd_beat == r_rlen);
      end else if (w_r_hs) begin
        r_rlast <= 1'b0;
      end
    end
  end

  assign o_rid   = r_rid;
  assign o_rdata = r_rdata;
  assign o_rresp = r_rresp;
  assign o_rlast = r_rlast;

  // ==========================================================================
  // Write FSM
  // ==========================================================================
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wstate <= W_IDLE;
    else     r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    o_awready    = 1'b0;
    o_wready     = 1'b0;
    o_bvalid     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        o_awready = r_live;
        if (r_live && i_awvalid) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        o_wready = 1'b1;
        // The beat counter, not wlast, decides where the burst ends.
        if (i_wvalid && w_w_final) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        o_bvalid = 1'b1;
        if (i_bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  assign w_aw_hs    = o_awready & i_awvalid;
  assign w_w_hs     = o_wready & i_wvalid;
  assign w_w_final  = (r_wbeat == r_wlen);
  assign w_werr_nxt = r_werr | w_wr_drop | w_wlast_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_waddr <= '0;
      r_wlen  <= '0;
      r_wbeat <= '0;
      r_werr  <= 1'b0;
      r_bid   <= '0;
      r_bresp <= 2'b00;
    end else begin
      if (w_aw_hs) begin
        r_waddr <= i_awaddr;
        r_wlen  <= i_awlen;
        r_wbeat <= '0;
        r_werr  <= 1'b0;
        r_bid   <= i_awid;
      end
      if (w_w_hs) begin
        r_waddr <= r_waddr + ADDR_WIDTH'(c_BYTES);
        r_wbeat <= r_wbeat + 8'd1;
        r_werr  <= w_werr_nxt;
        if (w_w_final) r_bresp <= w_werr_nxt ? 2'b10 : 2'b00;
      end
    end
  end

  assign o_bid   = r_bid;
  assign o_bresp = r_bresp;

  // Storage: never reset, so a reset mid-burst leaves contents intact.
  always_ff @(posedge clk) begin
    if (w_w_hs && !w_wr_drop) begin
      for (int i = 0; i < c_BYTES; i++) begin
        mem_r[c_IDX_W'(r_waddr[c_IDX_W-1:0] + c_IDX_W'(i))] <= i_wdata[8*i +: 8];
      end
    end
  end

  // ==========================================================================
  // Error checking (optional)
  // ==========================================================================
`ifdef AXI_MEM_ERR_EN
  assign w_rd_err    = |w_rd_addr[ADDR_WIDTH-1:c_IDX_W];
  assign w_wr_drop   = |r_waddr[ADDR_WIDTH-1:c_IDX_W];
  assign w_wlast_err = (i_wlast != w_w_final);
`else
  assign w_rd_err    = 1'b0;
  assign w_wr_drop   = 1'b0;
  assign w_wlast_err = 1'b0;
  wire w_unused_cfg  = i_wlast;
`endif

  // Size and burst type are fixed by the bus width; the fields are accepted
  // only for protocol completeness.
  wire w_unused_ctl = ^{i_arsize, i_arburst, i_awsize, i_awburst};

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_mem_slave
//  Purpose  : Self-checking bench for axi_mem_slave (default parameters).
//             Expected read beats and write responses are queued from a byte
//             model when stimulus is issued and compared as the DUT answers.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_mem_slave;

  localparam int c_DEPTH = 8192;
`ifdef AXI_MEM_ERR_EN
  localparam bit c_ERR = 1'b1;
`else
  localparam bit c_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  i_arid = '0;
  logic [31:0] i_araddr = '0;
  logic [7:0]  i_arlen = '0;
  logic [2:0]  i_arsize = 3'd1;
  logic [1:0]  i_arburst = 2'b01;
  logic        i_arvalid = 1'b0;
  logic        o_arready;
  logic [3:0]  o_rid;
  logic [15:0] o_rdata;
  logic [1:0]  o_rresp;
  logic        o_rlast;
  logic        o_rvalid;
  logic        i_rready = 1'b0;
  logic [3:0]  i_awid = '0;
  logic [31:0] i_awaddr = '0;
  logic [7:0]  i_awlen = '0;
  logic [2:0]  i_awsize = 3'd1;
  logic [1:0]  i_awburst = 2'b01;
  logic        i_awvalid = 1'b0;
  logic        o_awready;
  logic [15:0] i_wdata = '0;
  logic        i_wlast = 1'b0;
  logic        i_wvalid = 1'b0;
  logic        o_wready;
  logic [3:0]  o_bid;
  logic [1:0]  o_bresp;
  logic        o_bvalid;
  logic        i_bready = 1'b0;

  axi_mem_slave dut (
    .clk(clk), .rst(rst),
    .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
    .i_arburst(i_arburst), .i_arvalid(i_arvalid), .o_arready(o_arready),
    .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
    .o_rvalid(o_rvalid), .i_rready(i_rready),
    .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
    .i_awburst(i_awburst), .i_awvalid(i_awvalid), .o_awready(o_awready),
    .i_wdata(i_wdata), .i_wlast(i_wlast), .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic [1:0]  resp;
    logic [3:0]  id;
  } rbeat_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  rbeat_t     rq[$];
  bexp_t      bq[$];
  logic [7:0] model [0:c_DEPTH-1];
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic logic [12:0] idx(input logic [31:0] a);
    return a[12:0];
  endfunction

  function automatic logic [15:0] model_word(input logic [31:0] a);
    return {model[idx(a + 32'd1)], model[idx(a)]};
  endfunction

  // ---------------------------------------------------------------- write
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                          input int len, input logic [15:0] d [0:7]);
    logic [31:0] a;
    logic        drop;
    bexp_t       e;
    int          n;
    a    = addr;
    drop = 1'b0;
    for (int k = 0; k <= len; k++) begin
      if (c_ERR && (a >= c_DEPTH)) begin
        drop = 1'b1;
      end else begin
        model[idx(a)]         = d[k][7:0];
        model[idx(a + 32'd1)] = d[k][15:8];
      end
      a = a + 32'd2;
    end
    e.resp = drop ? 2'b10 : 2'b00;
    e.id   = id;
    bq.push_back(e);

    i_awid = id; i_awaddr = addr; i_awlen = len[7:0]; i_awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_awready && n < 100);
    n_checks++;
    if (!o_awready) begin n_fail++; $display("FAIL aw_timeout: awready=%b required 1", o_awready); end
    @(posedge clk); #1;
    i_awvalid = 1'b0;

    for (int k = 0; k <= len; k++) begin
      i_wdata = d[k]; i_wlast = (k == len); i_wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!o_wready && n < 100);
      n_checks++;
      if (!o_wready) begin n_fail++; $display("FAIL w_timeout beat %0d: wready=%b required 1", k, o_wready); end
      @(posedge clk); #1;
    end
    i_wvalid = 1'b0; i_wlast = 1'b0;

    i_bready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_bvalid && n < 100);
    e = bq.pop_front();
    n_checks++;
    if (o_bvalid !== 1'b1 || o_bresp !== e.resp || o_bid !== e.id) begin
      n_fail++;
      $display("FAIL bresp addr=%h: bvalid=%b bresp=%b bid=%h, required bvalid=1 bresp=%b bid=%h",
               addr, o_bvalid, o_bresp, o_bid, e.resp, e.id);
    end
    @(posedge clk); #1;
    i_bready = 1'b0;
  endtask

  // ---------------------------------------------------------------- read
  task automatic do_read(input string name, input logic [3:0] id,
                         input logic [31:0] addr, input int len, input logic [3:0] pat);
    logic [31:0] a;
    rbeat_t      e;
    int          n, cyc, beats;
    a = addr;
    for (int k = 0; k <= len; k++) begin
      e.id   = id;
      e.last = (k == len);
      if (c_ERR && (a >= c_DEPTH)) begin
        e.data = 16'h0000; e.resp = 2'b10;
      end else begin
        e.data = model_word(a); e.resp = 2'b00;
      end
      rq.push_back(e);
      a = a + 32'd2;
    end

    i_arid = id; i_araddr = addr; i_arlen = len[7:0]; i_arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_arready && n < 100);
    n_checks++;
    if (!o_arready) begin n_fail++; $display("FAIL %s ar_timeout: arready=%b required 1", name, o_arready); end
    @(posedge clk); #1;
    i_arvalid = 1'b0;

    cyc = 0;
    while (!o_rvalid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    n_checks++;
    if (cyc != 2) begin n_fail++; $display("FAIL %s rd_latency: got %0d cycles required 2", name, cyc); end

    beats = 0; cyc = 0;
    while (beats < len + 1 && cyc < 200) begin
      i_rready = pat[cyc % 4];
      if (!o_rvalid) break;
      e = rq[0];
      n_checks++;
      if (o_rdata !== e.data || o_rlast !== e.last || o_rresp !== e.resp || o_rid !== e.id) begin
        n_fail++;
        $display("FAIL %s beat %0d cyc %0d: data=%h last=%b resp=%b id=%h, required data=%h last=%b resp=%b id=%h",
                 name, beats, cyc, o_rdata, o_rlast, o_rresp, o_rid, e.data, e.last, e.resp, e.id);
      end
      if (i_rready) begin void'(rq.pop_front()); beats++; end
      @(posedge clk); #1;
      cyc++;
    end
    i_rready = 1'b0;
    n_checks++;
    if (beats != len + 1) begin
      n_fail++;
      $display("FAIL %s beat_count: got %0d beats required %0d", name, beats, len + 1);
      rq.delete();
    end
    n_checks++;
    if (o_rvalid !== 1'b0) begin n_fail++; $display("FAIL %s rvalid_after_last: got %b required 0", name, o_rvalid); end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    #2;
    n_checks++;
    if ({o_arready, o_awready, o_wready, o_rvalid, o_rlast, o_bvalid} !== 6'b0 ||
        o_rdata !== 16'h0 || o_rid !== 4'h0 || o_rresp !== 2'b00 || o_bid !== 4'h0 || o_bresp !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_outputs: ar=%b aw=%b w=%b rv=%b rl=%b bv=%b rdata=%h rid=%h rresp=%b bid=%h bresp=%b, required all 0",
               o_arready, o_awready, o_wready, o_rvalid, o_rlast, o_bvalid, o_rdata, o_rid, o_rresp, o_bid, o_bresp);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (o_arready !== 1'b0) begin n_fail++; $display("FAIL arready_before_edge: got %b required 0", o_arready); end
    @(posedge clk); #1;
    n_checks++;
    if (o_arready !== 1'b1 || o_awready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_release: arready=%b awready=%b required 1 1", o_arready, o_awready);
    end
  endtask

  task automatic test_write_burst();
    logic [15:0] d [0:7];
    d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0, 16'h0, 16'h0, 16'h0};
    do_write(4'h5, 32'h10, 3, d);
    n_checks++;
    if (dut.mem_r[16] !== 8'h11) begin n_fail++; $display("FAIL mem_0x10: got %h required 11", dut.mem_r[16]); end
    n_checks++;
    if (dut.mem_r[23] !== 8'h44) begin n_fail++; $display("FAIL mem_0x17: got %h required 44", dut.mem_r[23]); end
  endtask

  task automatic test_read_burst();
    do_read("read_burst", 4'h3, 32'h10, 3, 4'b1111);
  endtask

  task automatic test_backpressure();
    do_read("backpressure", 4'hA, 32'h10, 3, 4'b1001);
  endtask

  task automatic test_wrap();
    logic [15:0] d [0:7];
    d = '{16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    do_write(4'h1, 32'h0, 0, d);
    d = '{16'hCAFE, 16'hBEEF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    do_write(4'h2, 32'h1FFE, 1, d);
    do_read("wrap", 4'h7, 32'h1FFE, 1, 4'b1111);
  endtask

  task automatic test_concurrent();
    logic [15:0] d [0:7];
    logic [15:0] d2 [0:7];
    d  = '{16'hAAAA, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    d2 = '{16'h5555, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    do_write(4'h4, 32'h20, 0, d);
    // AR one cycle ahead of AW puts the read-data load on the same edge as
    // the W beat (RD_LAT=2 versus AW->W one cycle).
    fork
      do_read("concurrent_old", 4'h6, 32'h20, 0, 4'b1111);
      begin @(posedge clk); #1; do_write(4'h8, 32'h20, 0, d2); end
    join
    do_read("concurrent_new", 4'h6, 32'h20, 0, 4'b1111);
  endtask

  task automatic test_reset_mid_burst();
    int          cyc;
    logic [31:0] a;
    i_arid = 4'h9; i_araddr = 32'h10; i_arlen = 8'd3; i_arvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    i_arvalid = 1'b0;
    cyc = 0;
    while (!o_rvalid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    i_rready = 1'b1;
    a = 32'h10;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (o_rvalid !== 1'b1 || o_rdata !== model_word(a)) begin
        n_fail++; $display("FAIL mid_burst beat %0d: rvalid=%b data=%h required 1 %h", k, o_rvalid, o_rdata, model_word(a));
      end
      if (k < 2) begin @(posedge clk); #1; a = a + 32'd2; end
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (o_rvalid !== 1'b0 || o_rlast !== 1'b0 || o_rdata !== 16'h0 || o_arready !== 1'b0) begin
      n_fail++; $display("FAIL reset_abort: rvalid=%b rlast=%b rdata=%h arready=%b required 0 0 0000 0",
                         o_rvalid, o_rlast, o_rdata, o_arready);
    end
    i_rready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (o_arready !== 1'b0) begin n_fail++; $display("FAIL arready_held_after_abort: got %b required 0", o_arready); end
    @(posedge clk); #1;
    n_checks++;
    if (o_arready !== 1'b1) begin n_fail++; $display("FAIL arready_after_abort: got %b required 1", o_arready); end
    n_checks++;
    if (dut.mem_r[16] !== 8'h11) begin n_fail++; $display("FAIL mem_after_reset: got %h required 11", dut.mem_r[16]); end
    do_read("after_reset", 4'h2, 32'h10, 3, 4'b1111);
  endtask

  initial begin
    for (int i = 0; i < c_DEPTH; i++) model[i] = 8'h00;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_backpressure();
    test_wrap();
    test_concurrent();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
